// File: rtl/kbd_fifo.sv
// Keyboard event FIFO: resolves F0/E0 scancode prefixes into one event byte per key
// action and buffers the events for the CPU with a show-ahead head, count and status.
module kbd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_strobe,
  input  logic [7:0]            rx_ascii,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            q,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            key_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    key_cnt_q, key_cnt_d;
  logic          overflow_q, overflow_d;
  logic          up_flag_q, up_flag_d;

  logic          is_f0, is_e0, is_term, push_req, do_push, do_pop, wr_en;
  logic [7:0]    entry;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Decode the strobe, build the event byte and resolve push/pop/flush priority.
  always_comb begin
    is_f0      = rx_strobe && (rx_data == 8'hF0);
    is_e0      = rx_strobe && (rx_data == 8'hE0);
    is_term    = rx_strobe && !is_f0 && !is_e0;
    entry      = (rx_ascii[7:4] == 4'hE) ? rx_ascii : {up_flag_q, rx_ascii[6:0]};
    push_req   = is_term && (rx_ascii != 8'h00);
    do_push    = push_req && (!full || pop);
    do_pop     = pop && !empty;
    wr_en      = do_push && !flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    key_cnt_d  = key_cnt_q;
    overflow_d = overflow_q;
    up_flag_d  = up_flag_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      up_flag_d  = 1'b0;
    end else begin
      if (is_f0) up_flag_d = 1'b1;
      else if (is_term) up_flag_d = 1'b0;
      if (do_push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        key_cnt_d = key_cnt_q + 8'd1;
      end
      if (push_req && !do_push) overflow_d = 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      key_cnt_q  <= '0;
      overflow_q <= 1'b0;
      up_flag_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      key_cnt_q  <= key_cnt_d;
      overflow_q <= overflow_d;
      up_flag_q  <= up_flag_d;
    end
  end

  // Storage is not reset; only the pointers and count define its validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry;
  end

  assign q        = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign key_cnt  = key_cnt_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// Bench for kbd_fifo: queue-based event model checked every cycle, plus directed
// literal expectations from the test plan.
module tb_kbd_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data, rx_ascii;
  logic       rx_strobe, pop, flush;
  logic [7:0] q, key_cnt;
  logic [4:0] count;
  logic       empty, full, overflow;

  int n_cmp = 0;
  int n_err = 0;

  kbd_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_ascii(rx_ascii), .pop(pop), .flush(flush), .q(q), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .key_cnt(key_cnt)
  );

  always #5 clk = ~clk;

  // Event model: a queue of bytes plus the release-prefix flag.
  logic [7:0] mq[$];
  logic       m_up, m_ovf;
  logic [7:0] m_kc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); m_up = 1'b0; m_ovf = 1'b0; m_kc = 8'h00;
    end else if (flush) begin
      mq.delete(); m_up = 1'b0; m_ovf = 1'b0;
    end else begin
      logic       had_room;
      logic [7:0] ev;
      had_room = (mq.size() < 16);
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (rx_strobe) begin
        if (rx_data == 8'hF0) m_up = 1'b1;
        else if (rx_data != 8'hE0) begin
          ev = (rx_ascii >= 8'hE0 && rx_ascii <= 8'hEF) ? rx_ascii
                                                        : ((rx_ascii & 8'h7F) | (m_up ? 8'h80 : 8'h00));
          m_up = 1'b0;
          if (rx_ascii != 8'h00) begin
            if (had_room || pop) begin
              mq.push_back(ev); m_kc = m_kc + 8'd1;
            end else m_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_q",     int'(q),        (mq.size() > 0) ? int'(mq[0]) : 0);
      chk("m_count", int'(count),    mq.size());
      chk("m_empty", int'(empty),    (mq.size() == 0) ? 1 : 0);
      chk("m_full",  int'(full),     (mq.size() == 16) ? 1 : 0);
      chk("m_ovf",   int'(overflow), int'(m_ovf));
      chk("m_kc",    int'(key_cnt),  int'(m_kc));
    end
  end

  task automatic cyc(input logic s, input logic [7:0] d, input logic [7:0] a,
                     input logic p, input logic f);
    rx_strobe = s; rx_data = d; rx_ascii = a; pop = p; flush = f;
    @(posedge clk); #1;
    rx_strobe = 1'b0; rx_data = 8'h00; rx_ascii = 8'h00; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic key(input logic [7:0] d, input logic [7:0] a);
    cyc(1'b1, d, a, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00; rx_ascii = 8'h00;
    pop = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_kc", int'(key_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    key(8'h1C, 8'h61);
    chk("tp1_q", int'(q), 'h61); chk("tp1_count", int'(count), 1);
    chk("tp1_kc", int'(key_cnt), 1); chk("tp1_empty", int'(empty), 0);
    do_pop();
    chk("tp1_q_pop", int'(q), 0); chk("tp1_empty_pop", int'(empty), 1);

    key(8'hF0, 8'h00);
    chk("f0_nopush", int'(count), 0);
    key(8'h1C, 8'h61);
    chk("rel_q", int'(q), 'hE1);
    key(8'h1C, 8'h61);
    chk("rel_count", int'(count), 2);
    do_pop();
    chk("rel_second", int'(q), 'h61);
    do_pop();

    key(8'hE0, 8'h00);
    chk("e0_nopush", int'(count), 0);
    key(8'h75, 8'hE8);
    chk("ext_q", int'(q), 'hE8); chk("ext_count", int'(count), 1);
    do_pop();
    key(8'hF0, 8'h00); key(8'hE0, 8'h00); key(8'h75, 8'hE8);
    chk("ext_rel_q", int'(q), 'hE8);
    do_pop();
    key(8'hF0, 8'h00); key(8'h07, 8'h00);
    chk("unmapped", int'(count), 0);
    key(8'h1C, 8'h61);
    chk("unmapped_clr", int'(q), 'h61);
    do_pop();

    // Reset in the middle of a release sequence drops the prefix.
    key(8'hF0, 8'h00);
    do_reset();
    for (int i = 0; i < 16; i++) key(8'h1C, 8'(8'h41 + i));
    chk("fill_q", int'(q), 'h41);
    chk("fill_full", int'(full), 1); chk("fill_count", int'(count), 16);
    chk("fill_kc", int'(key_cnt), 'h10);
    key(8'h1C, 8'h5A);
    chk("ovf_set", int'(overflow), 1); chk("ovf_count", int'(count), 16);
    chk("ovf_kc", int'(key_cnt), 'h10);
    for (int i = 0; i < 16; i++) begin
      chk("drain_q", int'(q), 'h41 + i);
      do_pop();
    end
    chk("drain_empty", int'(empty), 1);
    do_pop();
    chk("underflow", int'(count), 0);

    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("flush_ovf", int'(overflow), 0); chk("flush_kc", int'(key_cnt), 'h10);
    for (int i = 0; i < 16; i++) key(8'h1C, 8'(8'h41 + i));
    cyc(1'b1, 8'h1C, 8'h51, 1'b1, 1'b0);
    chk("pp_full_count", int'(count), 16); chk("pp_full_ovf", int'(overflow), 0);
    chk("pp_full_kc", int'(key_cnt), 'h21); chk("pp_full_head", int'(q), 'h42);
    for (int i = 0; i < 15; i++) do_pop();
    chk("pp_last", int'(q), 'h51);
    do_pop();
    cyc(1'b1, 8'h1C, 8'h61, 1'b1, 1'b0);
    chk("pp_empty_count", int'(count), 1); chk("pp_empty_q", int'(q), 'h61);
    do_pop();

    key(8'h1C, 8'h31); key(8'h1C, 8'h32); key(8'h1C, 8'h33);
    chk("load3", int'(count), 3);
    key(8'hF0, 8'h00);
    cyc(1'b1, 8'h1C, 8'h61, 1'b1, 1'b1);
    chk("fl_count", int'(count), 0); chk("fl_ovf", int'(overflow), 0);
    chk("fl_kc", int'(key_cnt), 'h25);
    key(8'h1C, 8'h61);
    chk("fl_prefix_clr", int'(q), 'h61);
    do_pop();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
